// File: rtl/alu_defs.sv
// Shared definitions for the accumulator sequencer and its ALU.
// Holds the FSM state encoding and the {arit, ALUOp} command codes.
package alu_defs;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_WB   = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   // Opcode MSB is arit; logic ops occupy 3'b0xx.
   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_NOTA = 3'b011;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_SUB  = 3'b101;
   localparam logic [2:0] OP_NEGA = 3'b110;
   localparam logic [2:0] OP_NEGB = 3'b111;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU: add/sub/negate when arit=1, bitwise ops otherwise.
// Carry is the raw adder carry-out, so subtraction reports carry=1 for "no borrow".
module alu (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [1:0] alu_op,
   input  logic       arit,
   output logic [3:0] r,
   output logic       zero,
   output logic       carry,
   output logic       sign
);

   logic [4:0] sum;

   always_comb begin
      sum = 5'b0;
      if (arit) begin
         unique case (alu_op)
            2'b00: sum = {1'b0, a} + {1'b0, b};
            2'b01: sum = {1'b0, a} + {1'b0, ~b} + 5'd1;
            2'b10: sum = {1'b0, ~a} + 5'd1;
            2'b11: sum = {1'b0, ~b} + 5'd1;
            default: sum = 5'b0;
         endcase
      end else begin
         unique case (alu_op)
            2'b00: sum = {1'b0, a & b};
            2'b01: sum = {1'b0, a | b};
            2'b10: sum = {1'b0, a ^ b};
            2'b11: sum = {1'b0, ~a};
            default: sum = 5'b0;
         endcase
      end
   end

   assign r     = sum[3:0];
   assign zero  = (sum[3:0] == 4'd0);
   assign carry = arit & sum[4];
   assign sign  = sum[3];

endmodule

// File: rtl/alu_acc_ctrl.sv
// Multicycle accumulator stage around the combinational alu: accept a command,
// hold operands for SETTLE_CYC cycles, write back to acc/flags, then hand off the result.
module alu_acc_ctrl
   import alu_defs::*;
#(
   parameter logic [3:0]  ACC_INIT   = 4'b0000,
   parameter int unsigned SETTLE_CYC = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic       cmd_src,
   input  logic       cmd_clr,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [3:0] res_r,
   output logic       res_zero,
   output logic       res_carry,
   output logic       res_sign
);

   state_t     state;
   state_t     next_state;
   logic [3:0] acc;
   logic       zero_q;
   logic       carry_q;
   logic       sign_q;
   logic [3:0] a_q;
   logic [3:0] b_q;
   logic [2:0] op_q;
   logic       clr_q;
   logic [3:0] cnt;
   logic [3:0] alu_r;
   logic       alu_zero;
   logic       alu_carry;
   logic       alu_sign;

   // The ALU sees only the operand registers, so its inputs cannot move during EXEC.
   alu u_alu (
      .a      (a_q),
      .b      (b_q),
      .alu_op (op_q[1:0]),
      .arit   (op_q[2]),
      .r      (alu_r),
      .zero   (alu_zero),
      .carry  (alu_carry),
      .sign   (alu_sign)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         acc     <= ACC_INIT;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         sign_q  <= 1'b0;
         a_q     <= 4'd0;
         b_q     <= 4'd0;
         op_q    <= 3'd0;
         clr_q   <= 1'b0;
         cnt     <= 4'd0;
      end else begin
         state <= next_state;
         unique case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  // A from the accumulator means the value present at the accept edge.
                  a_q   <= cmd_src ? cmd_a : acc;
                  b_q   <= cmd_b;
                  op_q  <= cmd_op;
                  clr_q <= cmd_clr;
                  cnt   <= 4'(SETTLE_CYC - 1);
               end
            end
            ST_EXEC: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_WB: begin
               if (clr_q) begin
                  acc     <= ACC_INIT;
                  zero_q  <= 1'b0;
                  carry_q <= 1'b0;
                  sign_q  <= 1'b0;
               end else begin
                  // Sign is meaningless for logic ops and is masked so it never escapes.
                  acc     <= alu_r;
                  zero_q  <= alu_zero;
                  carry_q <= alu_carry;
                  sign_q  <= op_q[2] & alu_sign;
               end
            end
            ST_DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      next_state = state;
      cmd_ready  = 1'b0;
      res_valid  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               next_state = cmd_clr ? ST_WB : ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (cnt == 4'd0) begin
               next_state = ST_WB;
            end
         end
         ST_WB: begin
            next_state = ST_DONE;
         end
         ST_DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   assign res_r     = acc;
   assign res_zero  = zero_q;
   assign res_carry = carry_q;
   assign res_sign  = sign_q;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Self-checking bench for alu_acc_ctrl: directed scenarios followed by random commands,
// compared against an arithmetic reference model of the accumulator and flags.
module tb_alu_acc_ctrl;
   import alu_defs::*;

   localparam logic [3:0] ACC_INIT = 4'hA;
   localparam int         SETTLE   = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic       cmd_src;
   logic       cmd_clr;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_r;
   logic       res_zero;
   logic       res_carry;
   logic       res_sign;

   int checks   = 0;
   int failures = 0;

   logic [3:0] m_acc;
   logic       m_zero;
   logic       m_carry;
   logic       m_sign;

   alu_acc_ctrl #(
      .ACC_INIT   (ACC_INIT),
      .SETTLE_CYC (SETTLE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_src   (cmd_src),
      .cmd_clr   (cmd_clr),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_r     (res_r),
      .res_zero  (res_zero),
      .res_carry (res_carry),
      .res_sign  (res_sign)
   );

   always #5 clk = ~clk;

   // Reference result as {sign, carry, zero, r}, computed with integer arithmetic.
   function automatic logic [6:0] refAlu(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
      int         ia;
      int         ib;
      int         res;
      logic       c;
      logic [3:0] r;
      logic       s;
      ia  = int'(a);
      ib  = int'(b);
      res = 0;
      c   = 1'b0;
      case (op)
         OP_ADD:  begin res = ia + ib; c = (res > 15);  end
         OP_SUB:  begin res = ia - ib; c = (ia >= ib);  end
         OP_NEGA: begin res = -ia;     c = (ia == 0);   end
         OP_NEGB: begin res = -ib;     c = (ib == 0);   end
         OP_AND:  res = ia & ib;
         OP_OR:   res = ia | ib;
         OP_XOR:  res = ia ^ ib;
         default: res = 15 - ia;
      endcase
      r = 4'(res & 15);
      s = op[2] ? (res & 15) >= 8 : 1'b0;
      return {s, c, (r == 4'd0), r};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic checkRegs(input string tag);
      checkOutput({tag, "_r"},     32'(res_r),     32'(m_acc));
      checkOutput({tag, "_zero"},  32'(res_zero),  32'(m_zero));
      checkOutput({tag, "_carry"}, 32'(res_carry), 32'(m_carry));
      checkOutput({tag, "_sign"},  32'(res_sign),  32'(m_sign));
   endtask

   // Issues one command at a negedge, waits for the result, optionally stalls res_ready.
   task automatic applyStimulus(input logic [2:0] op, input logic src, input logic clr,
                                input logic [3:0] a, input logic [3:0] b, input int hold);
      int         waited;
      int         exp_lat;
      logic [6:0] e;
      logic [3:0] eff_a;
      waited = 0;
      while (!cmd_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!cmd_ready) begin
         checkOutput("ready_timeout", 32'(cmd_ready), 32'd1);
         return;
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_src   = src;
      cmd_clr   = clr;
      cmd_a     = a;
      cmd_b     = b;
      eff_a     = src ? a : m_acc;
      if (clr) begin
         m_acc = ACC_INIT; m_zero = 1'b0; m_carry = 1'b0; m_sign = 1'b0;
         exp_lat = 2;
      end else begin
         e = refAlu(op, eff_a, b);
         m_acc = e[3:0]; m_zero = e[4]; m_carry = e[5]; m_sign = e[6];
         exp_lat = SETTLE + 2;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 3'($urandom);
      cmd_src   = 1'($urandom);
      cmd_a     = 4'($urandom);
      cmd_b     = 4'($urandom);
      checkOutput("busy_ready", 32'(cmd_ready), 32'd0);
      waited = 1;
      while (!res_valid && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("latency", 32'(waited), 32'(exp_lat));
      checkRegs("result");
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'b1;
         cmd_clr   = 1'($urandom);
         cmd_src   = 1'b1;
         cmd_a     = 4'($urandom);
         @(negedge clk);
         checkOutput("hold_valid", 32'(res_valid), 32'd1);
         checkOutput("hold_ready", 32'(cmd_ready), 32'd0);
         checkRegs("hold");
      end
      cmd_valid = 1'b0;
      cmd_clr   = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checkOutput("release_valid", 32'(res_valid), 32'd0);
      checkOutput("release_ready", 32'(cmd_ready), 32'd1);
      checkRegs("after");
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_src   = 1'b0;
      cmd_clr   = 1'b0;
      cmd_a     = 4'd0;
      cmd_b     = 4'd0;
      res_ready = 1'b0;
      m_acc     = ACC_INIT;
      m_zero    = 1'b0;
      m_carry   = 1'b0;
      m_sign    = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      $display("[TB] reset released");
      checkRegs("reset");
      checkOutput("reset_valid", 32'(res_valid), 32'd0);
      checkOutput("reset_ready", 32'(cmd_ready), 32'd1);

      applyStimulus(OP_ADD,  1'b1, 1'b0, 4'd3, 4'd4, 0);
      applyStimulus(OP_SUB,  1'b0, 1'b0, 4'd0, 4'd7, 0);
      applyStimulus(OP_ADD,  1'b1, 1'b0, 4'd9, 4'd9, 0);
      applyStimulus(OP_NEGA, 1'b0, 1'b0, 4'd0, 4'd0, 0);
      applyStimulus(OP_XOR,  1'b1, 1'b0, 4'd5, 4'd3, 5);
      applyStimulus(OP_ADD,  1'b0, 1'b1, 4'd1, 4'd1, 0);
      applyStimulus(OP_OR,   1'b1, 1'b0, 4'd8, 4'd1, 0);
      applyStimulus(OP_NEGB, 1'b1, 1'b0, 4'd2, 4'd0, 1);

      // Reset with a command in EXEC drops it and restores the initial state.
      applyStimulus(OP_ADD, 1'b1, 1'b0, 4'd1, 4'd2, 0);
      cmd_valid = 1'b1;
      cmd_op    = OP_ADD;
      cmd_src   = 1'b1;
      cmd_a     = 4'd5;
      cmd_b     = 4'd6;
      @(negedge clk);
      cmd_valid = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_acc = ACC_INIT; m_zero = 1'b0; m_carry = 1'b0; m_sign = 1'b0;
      checkRegs("midreset");
      checkOutput("midreset_valid", 32'(res_valid), 32'd0);
      checkOutput("midreset_ready", 32'(cmd_ready), 32'd1);

      for (int n = 0; n < 40; n++) begin
         applyStimulus(3'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                       4'($urandom), 4'($urandom), $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
